// File: rtl/smachine_gpio_port.sv
// Register-mapped switch/LED port for the S-Machine CPU: synchronised, debounced switches with
// W1C edge-pending bits and a maskable level interrupt, plus a CPU-writable LED register.
module smachine_gpio_port #(
  parameter int unsigned NUM_SW          = 2,
  parameter int unsigned NUM_LED         = 2,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SW-1:0]  switch_in,
  output logic [NUM_LED-1:0] led_out,
  input  logic [1:0]         addr,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               rdata_valid,
  output logic               irq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] AddrSwState = 2'd0;
  localparam logic [1:0] AddrLed     = 2'd1;
  localparam logic [1:0] AddrPending = 2'd2;
  localparam logic [1:0] AddrMask    = 2'd3;

  logic [NUM_SW-1:0]  s1_q, s2_q;
  logic [NUM_SW-1:0]  deb_q, deb_d;
  logic [CntW-1:0]    cnt_q [NUM_SW];
  logic [CntW-1:0]    cnt_d [NUM_SW];
  logic [NUM_SW-1:0]  sw_edge;
  logic [NUM_SW-1:0]  pending_q, pending_d;
  logic [NUM_SW-1:0]  mask_q, mask_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic [NUM_SW-1:0]  pend_clr;
  logic [DATA_W-1:0]  rd_mux;
  logic [DATA_W-1:0]  rdata_q;
  logic               rdata_valid_q;
  logic               unused_wdata;

  // Only the low field bits of wdata are ever consumed.
  assign unused_wdata = ^wdata;

  always_comb begin
    deb_d   = deb_q;
    sw_edge = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        deb_d[i]   = s2_q[i];
        cnt_d[i]   = '0;
        sw_edge[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    led_d    = led_q;
    mask_d   = mask_q;
    pend_clr = '0;
    if (wr_en) begin
      unique case (addr)
        AddrSwState: ;
        AddrLed:     led_d    = wdata[NUM_LED-1:0];
        AddrPending: pend_clr = wdata[NUM_SW-1:0];
        AddrMask:    mask_d   = wdata[NUM_SW-1:0];
      endcase
    end
    // A newly accepted edge takes priority over a same-cycle W1C.
    pending_d = (pending_q & ~pend_clr) | sw_edge;
  end

  // Read mux sees pre-write state, so a simultaneous write/read returns the old value.
  always_comb begin
    rd_mux = '0;
    unique case (addr)
      AddrSwState: rd_mux[NUM_SW-1:0]  = deb_q;
      AddrLed:     rd_mux[NUM_LED-1:0] = led_q;
      AddrPending: rd_mux[NUM_SW-1:0]  = pending_q;
      AddrMask:    rd_mux[NUM_SW-1:0]  = mask_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q          <= '0;
      s2_q          <= '0;
      deb_q         <= '0;
      pending_q     <= '0;
      mask_q        <= '0;
      led_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q          <= switch_in;
      s2_q          <= s1_q;
      deb_q         <= deb_d;
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      led_q         <= led_d;
      rdata_valid_q <= rd_en;
      if (rd_en) begin
        rdata_q <= rd_mux;
      end
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign led_out     = led_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign irq         = |(pending_q & mask_q);

endmodule

// File: tb/tb_smachine_gpio_port.sv
// Directed bench for smachine_gpio_port: default instance plus an 8-switch, 1-cycle-debounce one.
module tb_smachine_gpio_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sw_in;
  logic [1:0]  led;
  logic [1:0]  addr;
  logic        wr_en, rd_en;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rvalid;
  logic        irq;

  logic [7:0]  sw8;
  logic [3:0]  led8;
  logic [1:0]  addr8;
  logic        wr8, rd8;
  logic [15:0] wdata8;
  logic [15:0] rdata8;
  logic        rvalid8;
  logic        irq8;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  smachine_gpio_port dut (
    .clk         (clk),
    .reset       (reset),
    .switch_in   (sw_in),
    .led_out     (led),
    .addr        (addr),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wdata       (wdata),
    .rdata       (rdata),
    .rdata_valid (rvalid),
    .irq         (irq)
  );

  smachine_gpio_port #(
    .NUM_SW          (8),
    .NUM_LED         (4),
    .DATA_W          (16),
    .DEBOUNCE_CYCLES (1)
  ) dut8 (
    .clk         (clk),
    .reset       (reset),
    .switch_in   (sw8),
    .led_out     (led8),
    .addr        (addr8),
    .wr_en       (wr8),
    .rd_en       (rd8),
    .wdata       (wdata8),
    .rdata       (rdata8),
    .rdata_valid (rvalid8),
    .irq         (irq8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
    addr  = a;
    rd_en = 1'b1;
    step();
    check(tag, 32'(rdata), 32'(exp));
    check({tag, "_valid"}, 32'(rvalid), 32'd1);
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sw_in = 2'b11;
    addr  = '0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    sw8   = '0;
    addr8 = '0;
    wr8   = 1'b0;
    rd8   = 1'b0;
    wdata8 = '0;

    // Reset for two cycles with switches high.
    step();
    step();
    check("rst_led", 32'(led), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_led8", 32'(led8), 32'd0);
    check("rst_rvalid8", 32'(rvalid8), 32'd0);
    reset = 1'b0;

    // First edge samples s1; deb updates on the 6th edge, visible to the 7th read.
    addr  = 2'd0;
    rd_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("rst_sw_pre", 32'(rdata), 32'd0);
      check("rst_sw_pre_valid", 32'(rvalid), 32'd1);
    end
    step();
    check("rst_sw_post", 32'(rdata), 32'd3);
    addr = 2'd2;
    step();
    check("rst_pending", 32'(rdata), 32'd3);
    rd_en = 1'b0;
    check("rst_irq_nomask", 32'(irq), 32'd0);

    // LED path.
    bus_wr(2'd1, 16'h0003);
    check("led_wr3", 32'(led), 32'd3);
    bus_rd("led_rd3", 2'd1, 16'h0003);
    step();
    check("led_rvalid_drop", 32'(rvalid), 32'd0);
    bus_wr(2'd1, 16'hFFFE);
    check("led_wrfffe", 32'(led), 32'd2);
    bus_rd("led_rd2", 2'd1, 16'h0002);

    // Bring switches low, then clear pending.
    sw_in = 2'b00;
    repeat (8) step();
    bus_wr(2'd2, 16'h0003);
    bus_rd("deb_pend_clr", 2'd2, 16'h0000);

    // 3-cycle glitch on switch 0 must be rejected.
    addr  = 2'd2;
    rd_en = 1'b1;
    sw_in = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step();
      check("glitch_pend_hi", 32'(rdata), 32'd0);
    end
    sw_in = 2'b00;
    for (int k = 0; k < 8; k++) begin
      step();
      check("glitch_pend_lo", 32'(rdata), 32'd0);
    end
    rd_en = 1'b0;
    bus_rd("glitch_sw", 2'd0, 16'h0000);

    // Held input accepted after full debounce.
    addr  = 2'd0;
    rd_en = 1'b1;
    sw_in = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("hold_sw_pre", 32'(rdata), 32'd0);
    end
    step();
    check("hold_sw_post", 32'(rdata), 32'd1);
    rd_en = 1'b0;
    bus_rd("hold_pend", 2'd2, 16'h0001);

    // Interrupt on switch 1 only.
    bus_wr(2'd3, 16'h0002);
    bus_rd("mask_rd", 2'd3, 16'h0002);
    check("irq_masked_out", 32'(irq), 32'd0);
    sw_in = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("irq_pre", 32'(irq), 32'd0);
    end
    step();
    check("irq_rise", 32'(irq), 32'd1);
    bus_rd("irq_pend", 2'd2, 16'h0003);
    bus_wr(2'd2, 16'h0002);
    check("irq_w1c_fall", 32'(irq), 32'd0);
    bus_rd("w1c_pend", 2'd2, 16'h0001);
    sw_in = 2'b01;
    repeat (6) step();
    check("irq_refire", 32'(irq), 32'd1);
    bus_wr(2'd2, 16'h0001);
    check("w1c_other_irq", 32'(irq), 32'd1);
    bus_rd("w1c_other_pend", 2'd2, 16'h0002);

    // W1C of bit 0 lands on the edge that accepts switch 0 falling.
    sw_in = 2'b00;
    repeat (5) step();
    bus_wr(2'd2, 16'h0001);
    bus_rd("race_pend", 2'd2, 16'h0003);

    // SW_STATE is read-only; MASK ignores bits above its field.
    bus_wr(2'd0, 16'hFFFF);
    bus_rd("sw_ro", 2'd0, 16'h0000);
    bus_wr(2'd3, 16'hFFFC);
    bus_rd("mask_trunc", 2'd3, 16'h0000);
    check("mask_trunc_irq", 32'(irq), 32'd0);

    // Parameter sweep instance: walking 1 with a 1-cycle debounce.
    addr8 = 2'd0;
    rd8   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] prev;
      logic [7:0] cur;
      prev = (i == 0) ? 8'h00 : 8'(1 << (i - 1));
      cur  = 8'(1 << i);
      sw8  = cur;
      for (int k = 1; k <= 3; k++) begin
        step();
        check("walk_pre", 32'(rdata8), 32'(prev));
      end
      step();
      check("walk_post", 32'(rdata8), 32'(cur));
    end
    addr8 = 2'd2;
    step();
    check("walk_pend", 32'(rdata8), 32'h00FF);
    rd8 = 1'b0;

    addr8  = 2'd1;
    wdata8 = 16'hFFFF;
    wr8    = 1'b1;
    step();
    wr8 = 1'b0;
    check("led8_out", 32'(led8), 32'h000F);
    rd8 = 1'b1;
    step();
    check("led8_rd", 32'(rdata8), 32'h000F);
    check("led8_rd_valid", 32'(rvalid8), 32'd1);
    rd8 = 1'b0;
    check("irq8", 32'(irq8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
